// File: rtl/gray_convert_arbiter.sv
// Frame-granular round-robin arbiter sharing one RGB->gray converter between two
// pixel streams, with a 2-stage valid/ready pipeline around the converter.
module gray_convert_arbiter #(
    parameter logic FIRST_PRI = 1'b0
) (
    input  logic        Sys_Clk,
    input  logic        Sys_Rst_n,
    input  logic        S0_Valid,
    output logic        S0_Ready,
    input  logic [23:0] S0_Data,
    input  logic        S0_Last,
    input  logic [4:0]  S0_Accuracy,
    input  logic        S1_Valid,
    output logic        S1_Ready,
    input  logic [23:0] S1_Data,
    input  logic        S1_Last,
    input  logic [4:0]  S1_Accuracy,
    output logic [7:0]  Conv_R,
    output logic [7:0]  Conv_G,
    output logic [7:0]  Conv_B,
    output logic [4:0]  Conv_Accuracy,
    input  logic [7:0]  Conv_Gray,
    output logic        M_Valid,
    input  logic        M_Ready,
    output logic [7:0]  M_Gray,
    output logic        M_Id,
    output logic        M_Last,
    output logic [15:0] Frame_Cnt_S0,
    output logic [15:0] Frame_Cnt_S1
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

    state_e           state_q;
    logic             last_srv_q;
    logic [4:0]       acc_q;

    logic             valid1_q, id1_q, last1_q;
    logic [7:0]       conv_r_q, conv_g_q, conv_b_q;
    logic [4:0]       conv_acc_q;

    logic             m_valid_q, m_id_q, m_last_q;
    logic [7:0]       m_gray_q;

    logic [1:0][15:0] frame_cnt_q, frame_cnt_d;

    logic [1:0]       req_vld, req_last, rdy, acc_beat;
    logic [1:0][23:0] req_data;
    logic             sel, beat;
    logic             s1_can_load, s2_can_load, s2_load;

    assign req_vld  = {S1_Valid, S0_Valid};
    assign req_last = {S1_Last, S0_Last};
    assign req_data = {S1_Data, S0_Data};

    assign s2_can_load = !m_valid_q || M_Ready;
    assign s1_can_load = !valid1_q || s2_can_load;
    assign s2_load     = valid1_q && s2_can_load;

    // Ready must fall in the same cycle the pipeline fills, so it stays combinational.
    assign rdy[0]   = (state_q == LOCK0) && s1_can_load;
    assign rdy[1]   = (state_q == LOCK1) && s1_can_load;
    assign acc_beat = req_vld & rdy;
    assign sel      = (state_q == LOCK1);
    assign beat     = |acc_beat;

    function automatic logic [4:0] clamp_acc(input logic [4:0] a);
        return (a > 5'd20) ? 5'd20 : a;
    endfunction

    // last_srv_q resets to the loser so FIRST_PRI wins the first contention.
    always_ff @(posedge Sys_Clk or negedge Sys_Rst_n) begin
        if (!Sys_Rst_n) begin
            state_q    <= IDLE;
            last_srv_q <= ~FIRST_PRI;
            acc_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_vld[0] && (!req_vld[1] || last_srv_q)) begin
                        state_q <= LOCK0;
                        acc_q   <= clamp_acc(S0_Accuracy);
                    end else if (req_vld[1]) begin
                        state_q <= LOCK1;
                        acc_q   <= clamp_acc(S1_Accuracy);
                    end
                end
                LOCK0: begin
                    if (acc_beat[0] && req_last[0]) begin
                        state_q    <= IDLE;
                        last_srv_q <= 1'b0;
                    end
                end
                LOCK1: begin
                    if (acc_beat[1] && req_last[1]) begin
                        state_q    <= IDLE;
                        last_srv_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Sys_Clk or negedge Sys_Rst_n) begin
        if (!Sys_Rst_n) begin
            valid1_q   <= 1'b0;
            id1_q      <= 1'b0;
            last1_q    <= 1'b0;
            conv_r_q   <= '0;
            conv_g_q   <= '0;
            conv_b_q   <= '0;
            conv_acc_q <= '0;
        end else if (beat) begin
            valid1_q   <= 1'b1;
            id1_q      <= sel;
            last1_q    <= req_last[sel];
            conv_r_q   <= req_data[sel][23:16];
            conv_g_q   <= req_data[sel][15:8];
            conv_b_q   <= req_data[sel][7:0];
            conv_acc_q <= acc_q;
        end else if (s2_load) begin
            valid1_q   <= 1'b0;
        end
    end

    always_ff @(posedge Sys_Clk or negedge Sys_Rst_n) begin
        if (!Sys_Rst_n) begin
            m_valid_q <= 1'b0;
            m_gray_q  <= '0;
            m_id_q    <= 1'b0;
            m_last_q  <= 1'b0;
        end else if (s2_load) begin
            m_valid_q <= 1'b1;
            m_gray_q  <= Conv_Gray;
            m_id_q    <= id1_q;
            m_last_q  <= last1_q;
        end else if (M_Ready) begin
            m_valid_q <= 1'b0;
        end
    end

    // A frame counts as complete when its Last beat is accepted; wraps naturally.
    for (genvar g = 0; g < 2; g++) begin : g_cnt
        always_comb begin
            frame_cnt_d[g] = frame_cnt_q[g];
            if (acc_beat[g] && req_last[g])
                frame_cnt_d[g] = frame_cnt_q[g] + 16'd1;
        end

        always_ff @(posedge Sys_Clk or negedge Sys_Rst_n) begin
            if (!Sys_Rst_n) frame_cnt_q[g] <= '0;
            else            frame_cnt_q[g] <= frame_cnt_d[g];
        end
    end

    assign S0_Ready      = rdy[0];
    assign S1_Ready      = rdy[1];
    assign Conv_R        = conv_r_q;
    assign Conv_G        = conv_g_q;
    assign Conv_B        = conv_b_q;
    assign Conv_Accuracy = conv_acc_q;
    assign M_Valid       = m_valid_q;
    assign M_Gray        = m_gray_q;
    assign M_Id          = m_id_q;
    assign M_Last        = m_last_q;
    assign Frame_Cnt_S0  = frame_cnt_q[0];
    assign Frame_Cnt_S1  = frame_cnt_q[1];

endmodule

// File: tb/tb_gray_convert_arbiter.sv
// Directed bench for gray_convert_arbiter with a behavioural converter attached.
module tb_gray_convert_arbiter;

    logic        Sys_Clk = 1'b0;
    logic        Sys_Rst_n;
    logic        S0_Valid, S0_Ready, S0_Last;
    logic        S1_Valid, S1_Ready, S1_Last;
    logic [23:0] S0_Data, S1_Data;
    logic [4:0]  S0_Accuracy, S1_Accuracy;
    logic [7:0]  Conv_R, Conv_G, Conv_B, Conv_Gray;
    logic [4:0]  Conv_Accuracy;
    logic        M_Valid, M_Ready, M_Id, M_Last;
    logic [7:0]  M_Gray;
    logic [15:0] Frame_Cnt_S0, Frame_Cnt_S1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 Sys_Clk = ~Sys_Clk;

    gray_convert_arbiter #(.FIRST_PRI(1'b0)) dut (
        .Sys_Clk(Sys_Clk), .Sys_Rst_n(Sys_Rst_n),
        .S0_Valid(S0_Valid), .S0_Ready(S0_Ready), .S0_Data(S0_Data),
        .S0_Last(S0_Last), .S0_Accuracy(S0_Accuracy),
        .S1_Valid(S1_Valid), .S1_Ready(S1_Ready), .S1_Data(S1_Data),
        .S1_Last(S1_Last), .S1_Accuracy(S1_Accuracy),
        .Conv_R(Conv_R), .Conv_G(Conv_G), .Conv_B(Conv_B),
        .Conv_Accuracy(Conv_Accuracy), .Conv_Gray(Conv_Gray),
        .M_Valid(M_Valid), .M_Ready(M_Ready), .M_Gray(M_Gray),
        .M_Id(M_Id), .M_Last(M_Last),
        .Frame_Cnt_S0(Frame_Cnt_S0), .Frame_Cnt_S1(Frame_Cnt_S1)
    );

    // Converter model: weights 76/150/30 normalised by 255 (accuracy-8 formula).
    function automatic logic [7:0] gm(input logic [23:0] p);
        int s;
        s = int'(p[23:16]) * 76 + int'(p[15:8]) * 150 + int'(p[7:0]) * 30;
        return 8'(s / 255);
    endfunction

    assign Conv_Gray = gm({Conv_R, Conv_G, Conv_B});

    typedef struct { logic [7:0] g; logic id; logic last; int c; } ob_t;
    typedef struct { logic id; int c; } ib_t;

    ob_t         oq[$];
    ib_t         iq[$];
    logic [28:0] cq[$];
    logic        pend = 1'b0;

    logic [23:0] px[2][8];
    logic [4:0]  ac[2][8];

    always @(posedge Sys_Clk) cyc <= cyc + 1;

    // Inputs are driven just after posedge, so negedge sees the values the next edge will take.
    always @(negedge Sys_Clk) begin
        if (pend) cq.push_back({Conv_R, Conv_G, Conv_B, Conv_Accuracy});
        pend <= Sys_Rst_n && ((S0_Valid && S0_Ready) || (S1_Valid && S1_Ready));
        if (Sys_Rst_n) begin
            if (S0_Valid && S0_Ready) iq.push_back('{1'b0, cyc});
            if (S1_Valid && S1_Ready) iq.push_back('{1'b1, cyc});
            if (M_Valid && M_Ready)   oq.push_back('{M_Gray, M_Id, M_Last, cyc});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic clear_logs();
        iq.delete(); oq.delete(); cq.delete();
    endtask

    task automatic do_reset();
        Sys_Rst_n = 1'b0;
        S0_Valid = 0; S0_Last = 0; S0_Data = '0; S0_Accuracy = '0;
        S1_Valid = 0; S1_Last = 0; S1_Data = '0; S1_Accuracy = '0;
        M_Ready = 1'b1;
        repeat (2) @(posedge Sys_Clk);
        #3 Sys_Rst_n = 1'b1;
        @(posedge Sys_Clk); #1;
    endtask

    task automatic drv(input bit id, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            if (id) begin
                S1_Valid = 1; S1_Data = px[1][i]; S1_Last = (i == n - 1); S1_Accuracy = ac[1][i];
            end else begin
                S0_Valid = 1; S0_Data = px[0][i]; S0_Last = (i == n - 1); S0_Accuracy = ac[0][i];
            end
            t = 0;
            forever begin
                @(negedge Sys_Clk);
                if (id ? S1_Ready : S0_Ready) break;
                t++;
                if (t > 100) begin
                    checks++; errors++;
                    $display("FAIL drv%0d_timeout: beat %0d got no Ready, required Ready within 100 cycles", id, i);
                    if (id) S1_Valid = 0; else S0_Valid = 0;
                    return;
                end
            end
            @(posedge Sys_Clk); #1;
        end
        if (id) begin S1_Valid = 0; S1_Last = 0; end
        else    begin S0_Valid = 0; S0_Last = 0; end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({S0_Ready, S1_Ready, M_Valid} !== 3'b000) begin
            errors++; $display("FAIL reset_ready_valid: got %b, required 000", {S0_Ready, S1_Ready, M_Valid});
        end
        checks++;
        if ({Conv_R, Conv_G, Conv_B, Conv_Accuracy} !== 29'd0) begin
            errors++; $display("FAIL reset_conv: got %h, required 0", {Conv_R, Conv_G, Conv_B, Conv_Accuracy});
        end
        checks++;
        if ({M_Gray, M_Id, M_Last} !== 10'd0) begin
            errors++; $display("FAIL reset_m_out: got %h, required 0", {M_Gray, M_Id, M_Last});
        end
        checks++;
        if ({Frame_Cnt_S0, Frame_Cnt_S1} !== 32'd0) begin
            errors++; $display("FAIL reset_cnt: got %h, required 0", {Frame_Cnt_S0, Frame_Cnt_S1});
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] eg[4];
        int c0;
        eg = '{8'd76, 8'd150, 8'd30, 8'd128};
        px[0][0] = 24'hFF0000; px[0][1] = 24'h00FF00; px[0][2] = 24'h0000FF; px[0][3] = 24'h808080;
        for (int i = 0; i < 4; i++) ac[0][i] = 5'd8;
        clear_logs();
        c0 = cyc;
        drv(0, 4);
        repeat (4) @(posedge Sys_Clk); #1;
        checks++;
        if (iq.size() !== 4 || oq.size() !== 4 || cq.size() !== 4) begin
            errors++; $display("FAIL single_counts: in %0d out %0d conv %0d, required 4 each", iq.size(), oq.size(), cq.size());
        end else begin
            checks++;
            if (iq[0].c !== c0 + 1) begin
                errors++; $display("FAIL single_grant_latency: accept cycle %0d, required %0d", iq[0].c, c0 + 1);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (oq[i].g !== eg[i] || oq[i].id !== 1'b0 || oq[i].last !== (i == 3)) begin
                    errors++; $display("FAIL single_beat%0d: gray %0d id %b last %b, required gray %0d id 0 last %b",
                                       i, oq[i].g, oq[i].id, oq[i].last, eg[i], (i == 3));
                end
                checks++;
                if (oq[i].c - iq[i].c !== 2) begin
                    errors++; $display("FAIL single_latency%0d: got %0d cycles, required 2", i, oq[i].c - iq[i].c);
                end
                checks++;
                if (cq[i] !== {px[0][i], 5'd8}) begin
                    errors++; $display("FAIL single_conv%0d: got %h, required %h", i, cq[i], {px[0][i], 5'd8});
                end
            end
        end
        checks++;
        if (Frame_Cnt_S0 !== 16'd1 || Frame_Cnt_S1 !== 16'd0) begin
            errors++; $display("FAIL single_cnt: got %0d/%0d, required 1/0", Frame_Cnt_S0, Frame_Cnt_S1);
        end
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            px[0][i] = 24'h204060 + 24'h010101 * i; ac[0][i] = 5'd8;
            px[1][i] = 24'h604020 + 24'h020202 * i; ac[1][i] = 5'd8;
        end
        clear_logs();
        fork
            begin drv(0, 3); drv(0, 3); end
            begin drv(1, 3); drv(1, 3); end
        join
        repeat (4) @(posedge Sys_Clk); #1;
        checks++;
        if (iq.size() !== 12 || oq.size() !== 12) begin
            errors++; $display("FAIL contention_counts: in %0d out %0d, required 12/12", iq.size(), oq.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (iq[k].id !== 1'((k / 3) % 2) || oq[k].id !== 1'((k / 3) % 2) || oq[k].last !== (k % 3 == 2)) begin
                    errors++; $display("FAIL contention_order%0d: in id %b out id %b last %b, required id %0d last %b",
                                       k, iq[k].id, oq[k].id, oq[k].last, (k / 3) % 2, (k % 3 == 2));
                end
                if (k > 0) begin
                    checks++;
                    if (iq[k].c - iq[k-1].c !== ((k % 3 == 0) ? 2 : 1)) begin
                        errors++; $display("FAIL contention_gap%0d: got %0d, required %0d",
                                           k, iq[k].c - iq[k-1].c, (k % 3 == 0) ? 2 : 1);
                    end
                end
            end
        end
        checks++;
        if (Frame_Cnt_S0 !== 16'd2 || Frame_Cnt_S1 !== 16'd2) begin
            errors++; $display("FAIL contention_cnt: got %0d/%0d, required 2/2", Frame_Cnt_S0, Frame_Cnt_S1);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] g0;
        int t;
        for (int i = 0; i < 6; i++) begin px[0][i] = 24'h0A1428 + 24'h111111 * i; ac[0][i] = 5'd8; end
        clear_logs();
        fork
            drv(0, 6);
            begin
                M_Ready = 1'b0;
                repeat (3) @(posedge Sys_Clk); #1;
                g0 = M_Gray;
                repeat (3) @(posedge Sys_Clk); #1;
                checks++;
                if (iq.size() !== 2) begin
                    errors++; $display("FAIL bp_buffered: got %0d beats accepted, required 2", iq.size());
                end
                checks++;
                if (S0_Ready !== 1'b0 || M_Valid !== 1'b1) begin
                    errors++; $display("FAIL bp_stall: Ready %b M_Valid %b, required 0/1", S0_Ready, M_Valid);
                end
                checks++;
                if (M_Gray !== g0 || M_Gray !== gm(px[0][0])) begin
                    errors++; $display("FAIL bp_stable: got %0d (earlier %0d), required %0d", M_Gray, g0, gm(px[0][0]));
                end
                M_Ready = 1'b1;
            end
        join
        t = 0;
        while (oq.size() < 6 && t < 50) begin @(posedge Sys_Clk); t++; end
        repeat (3) @(posedge Sys_Clk); #1;
        checks++;
        if (oq.size() !== 6) begin
            errors++; $display("FAIL bp_drain_count: got %0d beats, required 6", oq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (oq[i].g !== gm(px[0][i]) || oq[i].id !== 1'b0 || oq[i].last !== (i == 5)) begin
                    errors++; $display("FAIL bp_beat%0d: gray %0d last %b, required gray %0d last %b",
                                       i, oq[i].g, oq[i].last, gm(px[0][i]), (i == 5));
                end
            end
        end
        checks++;
        if (Frame_Cnt_S0 !== 16'd3) begin
            errors++; $display("FAIL bp_cnt: got %0d, required 3", Frame_Cnt_S0);
        end
    endtask

    task automatic test_accuracy();
        px[1][0] = 24'h102030; px[1][1] = 24'h405060; px[1][2] = 24'h708090; px[1][3] = 24'hA0B0C0;
        ac[1][0] = 5'd31; ac[1][1] = 5'd2; ac[1][2] = 5'd2; ac[1][3] = 5'd2;
        clear_logs();
        drv(1, 4);
        repeat (4) @(posedge Sys_Clk); #1;
        checks++;
        if (cq.size() !== 4) begin
            errors++; $display("FAIL acc_count: got %0d, required 4", cq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cq[i] !== {px[1][i], 5'd20}) begin
                    errors++; $display("FAIL acc_clamp%0d: got %h, required %h", i, cq[i], {px[1][i], 5'd20});
                end
            end
        end
        checks++;
        if (Frame_Cnt_S1 !== 16'd3) begin
            errors++; $display("FAIL acc_cnt_s1: got %0d, required 3", Frame_Cnt_S1);
        end
        px[0][0] = 24'h112233; ac[0][0] = 5'd21;
        clear_logs();
        drv(0, 1);
        repeat (3) @(posedge Sys_Clk); #1;
        checks++;
        if (cq.size() !== 1 || cq[0] !== {24'h112233, 5'd20}) begin
            errors++; $display("FAIL acc_clamp21: got %0d entries first %h, required 1 entry %h",
                               cq.size(), (cq.size() > 0) ? cq[0] : 29'd0, {24'h112233, 5'd20});
        end
    endtask

    task automatic test_reset_mid();
        int n, t;
        clear_logs();
        S0_Valid = 1; S0_Data = 24'h203040; S0_Last = 0; S0_Accuracy = 5'd8;
        n = 0; t = 0;
        while (n < 2 && t < 50) begin
            @(negedge Sys_Clk);
            if (S0_Ready) n++;
            t++;
        end
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL rmid_accept: got %0d beats, required 2", n);
        end
        @(posedge Sys_Clk); #2;
        Sys_Rst_n = 1'b0; S0_Valid = 0;
        #1;
        checks++;
        if ({S0_Ready, S1_Ready, M_Valid} !== 3'b000 || {Conv_R, Conv_G, Conv_B, Conv_Accuracy} !== 29'd0) begin
            errors++; $display("FAIL rmid_async: rdy/valid %b conv %h, required 000 and 0",
                               {S0_Ready, S1_Ready, M_Valid}, {Conv_R, Conv_G, Conv_B, Conv_Accuracy});
        end
        checks++;
        if ({M_Gray, M_Id, M_Last} !== 10'd0 || {Frame_Cnt_S0, Frame_Cnt_S1} !== 32'd0) begin
            errors++; $display("FAIL rmid_outs: m %h cnt %h, required 0 and 0", {M_Gray, M_Id, M_Last}, {Frame_Cnt_S0, Frame_Cnt_S1});
        end
        repeat (2) @(posedge Sys_Clk);
        #3 Sys_Rst_n = 1'b1;
        @(posedge Sys_Clk); #1;
        clear_logs();
        px[0][0] = 24'h00FF00; px[0][1] = 24'hFF0000; ac[0][0] = 5'd8; ac[0][1] = 5'd8;
        t = cyc;
        drv(0, 2);
        repeat (4) @(posedge Sys_Clk); #1;
        checks++;
        if (oq.size() !== 2 || iq.size() !== 2) begin
            errors++; $display("FAIL rmid_new_count: in %0d out %0d, required 2/2", iq.size(), oq.size());
        end else begin
            checks++;
            if (iq[0].c !== t + 1) begin
                errors++; $display("FAIL rmid_grant: accept cycle %0d, required %0d", iq[0].c, t + 1);
            end
            checks++;
            if (oq[0].g !== 8'd150 || oq[1].g !== 8'd76 || oq[0].last !== 1'b0 || oq[1].last !== 1'b1) begin
                errors++; $display("FAIL rmid_new_data: got %0d/%0d last %b%b, required 150/76 last 01",
                                   oq[0].g, oq[1].g, oq[0].last, oq[1].last);
            end
        end
        checks++;
        if (Frame_Cnt_S0 !== 16'd1 || Frame_Cnt_S1 !== 16'd0) begin
            errors++; $display("FAIL rmid_cnt: got %0d/%0d, required 1/0", Frame_Cnt_S0, Frame_Cnt_S1);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_contention();
        test_backpressure();
        test_accuracy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_convert_arbiter.md
# gray_convert_arbiter

Shares one external RGB-to-grayscale converter between two pixel-stream requesters. Grants are per frame with round-robin fairness and pass the frame's precision setting to the converter. Results return on one tagged output stream through a 2-stage valid/ready pipeline. The block sits between the camera/DMA pixel sources and the gray-domain image processing chain.

## Interface
- FIRST_PRI, default 0: requester given priority on the first contended arbitration after reset (0 or 1).
- Sys_Clk  in  1  system clock; all logic rising-edge.
- Sys_Rst_n  in  1  asynchronous, active-low reset.
- S0_Valid / S1_Valid  in  1  requester beat valid.
- S0_Ready / S1_Ready  out  1  requester beat accepted when Valid && Ready.
- S0_Data / S1_Data  in  24  pixel {R[23:16], G[15:8], B[7:0]}.
- S0_Last / S1_Last  in  1  last beat of frame.
- S0_Accuracy / S1_Accuracy  in  5  grayscale precision for the frame; sampled at grant.
- Conv_R, Conv_G, Conv_B  out  8 each  converter pixel inputs, registered.
- Conv_Accuracy  out  5  converter precision input, registered.
- Conv_Gray  in  8  converter result, combinational from the Conv_* outputs.
- M_Valid  out  1  output beat valid.
- M_Ready  in  1  downstream accept.
- M_Gray  out  8  grayscale result.
- M_Id  out  1  source requester of the beat.
- M_Last  out  1  last beat of frame.
- Frame_Cnt_S0 / Frame_Cnt_S1  out  16  completed-frame counters; wrap at 0xFFFF to 0.

## Operation
- Arbiter FSM states: IDLE, LOCK0, LOCK1. Reset state is IDLE.
- IDLE:
  - If only Sx_Valid is high, go to LOCKx.
  - If both are high, go to LOCK of the requester not served last. After reset, the "last served" pointer is set so that FIRST_PRI wins.
  - On the transition, latch Sx_Accuracy into the accuracy register. Values 21..31 are clamped to 20.
- LOCKx:
  - Sx_Ready = stage1_can_load. The other requester's Ready is 0.
  - On an accepted beat with Sx_Last=1: go to IDLE, set last-served pointer to x, and increment Frame_Cnt_Sx.
  - Frames never interleave. The accuracy register is constant for the whole frame.
- Stage 1 loads on an accepted beat:
  - Conv_R/G/B take the beat's pixel bytes; Conv_Accuracy takes the accuracy register.
  - Stage 1 also holds valid1, id1 and last1.
  - stage1_can_load = !valid1 || stage2_can_load.
- Stage 2 loads when valid1 && stage2_can_load:
  - M_Gray takes Conv_Gray; M_Id and M_Last take id1 and last1.
  - M_Valid is set.
  - stage2_can_load = !M_Valid || M_Ready.
  - If stage 2 does not load, M_Valid keeps its value, except it clears when M_Ready=1.
- Stage registers hold their values while stalled. M_* outputs are stable while M_Valid && !M_Ready.
- The block performs no arithmetic on pixel data. The accuracy clamp is the only transform.

## Timing
- Reset values:
  - FSM = IDLE.
  - All Ready = 0; M_Valid = 0; valid1 = 0.
  - Conv_R/G/B = 0, Conv_Accuracy = 0.
  - M_Gray = 0, M_Id = 0, M_Last = 0.
  - Frame counters = 0.
- Grant latency: Sx_Valid seen in IDLE at edge n → Sx_Ready high in cycle n+1, provided stage 1 can load.
- Data latency: a beat accepted at edge n has M_Valid=1 after edge n+2, with no stall.
- Throughput: 1 beat/cycle within a frame. There is a 1-cycle IDLE bubble between frames.
- Backpressure: with M_Ready held low, at most 2 beats are buffered, then Sx_Ready drops in the same cycle (combinational).
- Simultaneous events:
  - A Last beat accepted while the other requester is valid → IDLE, then the other requester is granted the next cycle.
  - Accuracy input changes mid-frame are ignored.
- Reset mid-frame: in-flight beats are discarded immediately (asynchronous). Frame counters are not incremented for the partial frame.
- A requester dropping Valid mid-frame keeps the lock; the arbiter waits indefinitely for its Last.

## Test plan
- Single frame, S0 only:
  - Stimulus: 4 beats at accuracy 8; pixel 0xFF0000, then 0x00FF00, 0x0000FF, 0x808080; Last on beat 4; converter model attached.
  - Required response: M_Gray = 76, 150, 30, 128 (Accuracy 8 formula); M_Id=0; M_Last only on beat 4; Frame_Cnt_S0=1; 2-cycle latency.
- Contention:
  - Stimulus: both requesters continuously valid with 3-beat frames; FIRST_PRI=0.
  - Required response: frame order S0, S1, S0, S1; no interleaving within a frame; 1 bubble cycle between frames.
- Backpressure:
  - Stimulus: M_Ready low for 5 cycles during a frame.
  - Required response: exactly 2 beats buffered; S0_Ready low while full; M_Gray stable; no loss or duplication after release.
- Accuracy handling:
  - Stimulus: S1_Accuracy=31 at grant, then changed to 2 mid-frame.
  - Required response: Conv_Accuracy=20 for the entire frame.
- Reset mid-frame:
  - Stimulus: assert Sys_Rst_n low asynchronously mid-cycle after 2 accepted beats.
  - Required response: all outputs reach reset values immediately; counters stay 0; a new frame after release starts cleanly in IDLE.
